gcd_stim_driver: RTL and testbench

Synthesizable on-chip stimulus and checking block for the GCD engine. It sits on the engine's input side and plays the same role as the simulation bench, but in hardware. It generates operand pairs in a bounded range, launches the engine, and waits for its `done` edge. It compares the engine's result against an internal subtraction-based reference and accumulates pass, fail and timeout counts until `NUM_TESTS` pairs have been run.

---
 rtl/gcd_stim_driver_if.sv | 28 ++
 rtl/gcd_stim_driver.sv | 164 ++++++++++++++++
 tb/tb_gcd_stim_driver.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_stim_driver_if.sv
// Handshake and status bundle between the GCD stimulus driver and the engine.
interface gcd_stim_driver_if #(
  parameter int unsigned WIDTH = 32
);
  logic             done_in;
  logic [WIDTH-1:0] gcd_in;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             eng_rst;
  logic [15:0]      test_cnt;
  logic [15:0]      pass_cnt;
  logic [15:0]      fail_cnt;
  logic [15:0]      timeout_cnt;
  logic             err_pulse;
  logic             finished;

  modport master (
    input  done_in, gcd_in,
    output a_out, b_out, eng_rst, test_cnt, pass_cnt, fail_cnt,
           timeout_cnt, err_pulse, finished
  );

  modport slave (
    output done_in, gcd_in,
    input  a_out, b_out, eng_rst, test_cnt, pass_cnt, fail_cnt,
           timeout_cnt, err_pulse, finished
  );
endinterface

// File: rtl/gcd_stim_driver.sv
// On-chip stimulus/checker for the GCD engine: generates bounded operand
// pairs, launches the engine, checks its result against a subtractive
// reference and keeps pass/fail/timeout statistics.
module gcd_stim_driver #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_TESTS = 1000,
  parameter int unsigned MIN_VAL   = 10,
  parameter int unsigned MAX_VAL   = 1000,
  parameter int unsigned FIRST_A   = 14,
  parameter int unsigned FIRST_B   = 161,
  parameter logic [31:0] SEED      = 32'hACE1,
  parameter int unsigned TIMEOUT   = 4096
) (
  input logic              clk,
  input logic              rst,
  gcd_stim_driver_if.master bus
);

  localparam int unsigned RANGE = MAX_VAL - MIN_VAL + 1;
  localparam int unsigned K     = (RANGE > 1) ? $clog2(RANGE) : 1;
  localparam logic [31:0] TAPS  = 32'h80200003;

  typedef enum logic [2:0] {
    IDLE, GEN_A, GEN_B, LAUNCH, WAIT, CHECK, NEXT, FINISH
  } state_t;

  state_t           state, nstate;
  logic [31:0]      lfsr;
  logic [WIDTH-1:0] a_q, b_q, ra, rb, gcd_q;
  logic [31:0]      to_cnt;
  logic             eng_seen, to_flag, done_q, err_q;
  logic [15:0]      test_cnt, pass_cnt, fail_cnt, timeout_cnt;

  logic [K-1:0]     cand;
  logic             cand_ok;
  logic [WIDTH-1:0] operand;
  logic             edge_det, ref_done, timeout_hit, done_all;
  logic [15:0]      test_inc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  assign cand        = lfsr[K-1:0];
  assign cand_ok     = (32'(cand) <= RANGE - 1);
  assign operand     = WIDTH'(MIN_VAL) + WIDTH'(cand);
  assign edge_det    = (state == WAIT) && bus.done_in && !done_q;
  assign ref_done    = (ra == rb);
  assign timeout_hit = (state == WAIT) && !eng_seen && !edge_det &&
                       (to_cnt == 32'(TIMEOUT - 1));
  assign test_inc    = sat_inc(test_cnt);
  assign done_all    = (32'(test_inc) == NUM_TESTS);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state selection, including rejection-sampling retries in GEN_A/GEN_B.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:   nstate = LAUNCH;
      GEN_A:  if (cand_ok) nstate = GEN_B;
      GEN_B:  if (cand_ok) nstate = LAUNCH;
      LAUNCH: nstate = WAIT;
      WAIT: begin
        if ((eng_seen || edge_det) && ref_done) nstate = CHECK;
        else if (timeout_hit)                   nstate = CHECK;
      end
      CHECK:  nstate = NEXT;
      NEXT:   nstate = done_all ? FINISH : GEN_A;
      FINISH: nstate = FINISH;
      default: nstate = IDLE;
    endcase
  end

  // Edges are only accepted inside WAIT and done_q follows done_in through
  // LAUNCH, so a done level already present at launch never counts as a
  // completion; a fresh low-to-high transition is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= bus.done_in;
  end

  // Operand generation, reference unit, engine result capture and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr        <= SEED;
      a_q         <= '0;
      b_q         <= '0;
      ra          <= '0;
      rb          <= '0;
      gcd_q       <= '0;
      to_cnt      <= '0;
      eng_seen    <= 1'b0;
      to_flag     <= 1'b0;
      err_q       <= 1'b0;
      test_cnt    <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          a_q <= WIDTH'(FIRST_A);
          b_q <= WIDTH'(FIRST_B);
        end
        GEN_A: begin
          lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
          if (cand_ok) a_q <= operand;
        end
        GEN_B: begin
          lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
          if (cand_ok) b_q <= operand;
        end
        LAUNCH: begin
          ra       <= a_q;
          rb       <= b_q;
          to_cnt   <= '0;
          eng_seen <= 1'b0;
          to_flag  <= 1'b0;
        end
        WAIT: begin
          if (ra > rb)      ra <= ra - rb;
          else if (rb > ra) rb <= rb - ra;
          if (to_cnt != '1) to_cnt <= to_cnt + 32'd1;
          if (edge_det) begin
            gcd_q    <= bus.gcd_in;
            eng_seen <= 1'b1;
          end
          if (timeout_hit) to_flag <= 1'b1;
        end
        CHECK: begin
          if (to_flag) begin
            fail_cnt    <= sat_inc(fail_cnt);
            timeout_cnt <= sat_inc(timeout_cnt);
            err_q       <= 1'b1;
          end else if (gcd_q == ra) begin
            pass_cnt <= sat_inc(pass_cnt);
          end else begin
            fail_cnt <= sat_inc(fail_cnt);
            err_q    <= 1'b1;
          end
        end
        NEXT:    test_cnt <= test_inc;
        default: ;
      endcase
    end
  end

  assign bus.a_out       = a_q;
  assign bus.b_out       = b_q;
  assign bus.eng_rst     = rst || (state == LAUNCH) || (state == FINISH);
  assign bus.test_cnt    = test_cnt;
  assign bus.pass_cnt    = pass_cnt;
  assign bus.fail_cnt    = fail_cnt;
  assign bus.timeout_cnt = timeout_cnt;
  assign bus.err_pulse   = err_q;
  assign bus.finished    = (state == FINISH);

endmodule

// File: tb/tb_gcd_stim_driver.sv
// Self-checking bench for gcd_stim_driver with a behavioural mock GCD engine.
module tb_gcd_stim_driver;
  localparam int unsigned W    = 32;
  localparam int unsigned NT   = 8;
  localparam int unsigned TO   = 64;
  localparam int unsigned MINV = 10;
  localparam int unsigned MAXV = 1000;
  localparam int unsigned KB   = $clog2(MAXV - MINV + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_stim_driver_if #(.WIDTH(W)) bus();
  gcd_stim_driver #(.WIDTH(W), .NUM_TESTS(NT), .MIN_VAL(MINV), .MAX_VAL(MAXV),
                    .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Per-test mock behaviour plus the hand-derived outcome for that test.
  typedef struct {
    int unsigned delay;
    int unsigned off;
    bit          nodone;
    bit          stale;
    bit          exp_ok;
    bit          exp_to;
  } cfg_t;

  cfg_t        cfg [0:15];
  int          passed = 0;
  int          total  = 0;
  int unsigned cyc = 0;
  int          base = 0;
  int          launches = 0;
  int unsigned launch_cyc = 0;
  int          err_total = 0;
  int          err_run = 0;
  int          err_maxw = 0;
  logic [31:0] lfsr_m;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input bit ok, input longint act, input longint exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic check_eq(input string nm, input longint act, input longint exp);
    check(nm, act == exp, act, exp);
  endtask

  function automatic longint gcd_ref(input longint a, input longint b);
    longint x = a, y = b, t;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Next operand from the seeded Galois sequence with rejection of out-of-range draws.
  function automatic longint draw();
    longint c;
    forever begin
      c = longint'(lfsr_m & ((32'd1 << KB) - 32'd1));
      lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 32'h80200003 : 32'h0);
      if (c <= longint'(MAXV - MINV)) return longint'(MINV) + c;
    end
  endfunction

  // Mock engine: reacts to each launch according to the active table entry.
  initial begin
    cfg_t mc;
    longint mg;
    int unsigned mcnt;
    bit mact;
    mc = '{0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    mg = 0; mcnt = 0; mact = 1'b0;
    bus.done_in = 1'b0;
    bus.gcd_in  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        launches = 0; mact = 1'b0; bus.done_in = 1'b0;
      end else if (bus.eng_rst && !bus.finished) begin
        mc = cfg[base + launches];
        mg = gcd_ref(longint'(bus.a_out), longint'(bus.b_out));
        launch_cyc = cyc;
        launches++;
        mcnt = 0; mact = 1'b1;
        if (mc.stale) begin bus.done_in = 1'b1; bus.gcd_in = W'(mg + 1); end
        else bus.done_in = 1'b0;
      end else if (mact) begin
        mcnt++;
        if (mc.stale && mcnt == 3) bus.done_in = 1'b0;
        if (!mc.nodone && mcnt == mc.delay) begin
          bus.done_in = 1'b1;
          bus.gcd_in  = W'(mg + longint'(mc.off));
        end
      end
    end
  end

  // err_pulse monitor: total asserted cycles and longest contiguous run.
  always @(negedge clk) begin
    if (rst) begin err_total = 0; err_run = 0; end
    else if (bus.err_pulse) begin
      err_total++; err_run++;
      if (err_run > err_maxw) err_maxw = err_run;
    end else err_run = 0;
  end

  task automatic wait_launch(input int n, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (launches >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check({nm, "_launch"}, ok, launches, n);
  endtask

  task automatic wait_tests(input int n, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (int'(bus.test_cnt) >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check({nm, "_done"}, ok, bus.test_cnt, n);
  endtask

  initial begin
    longint ea, eb;
    int ep, ef, et;
    int unsigned delta;
    int dev;
    logic [W-1:0] sa, sb;
    logic [15:0]  sc [4];

    // Run A (full run), run B (wrong result then mid-test reset), run C (restart).
    cfg[0]  = '{20, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    cfg[1]  = '{0,  0, 1'b1, 1'b0, 1'b0, 1'b1};
    cfg[2]  = '{TO, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    cfg[3]  = '{$urandom_range(40, 6), 0, 1'b0, 1'b1, 1'b1, 1'b0};
    cfg[4]  = '{$urandom_range(50, 1), 1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 5; i < 8; i++) cfg[i] = '{$urandom_range(50, 1), 0, 1'b0, 1'b0, 1'b1, 1'b0};
    cfg[8]  = '{15, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    cfg[9]  = '{$urandom_range(30, 1), 0, 1'b0, 1'b0, 1'b1, 1'b0};
    cfg[10] = '{0,  0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 11; i < 16; i++) cfg[i] = '{20, 0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset values while rst is held.
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_a", bus.a_out, 0);
    check_eq("rst_b", bus.b_out, 0);
    check_eq("rst_eng_rst", bus.eng_rst, 1);
    check_eq("rst_cnts", {bus.test_cnt, bus.pass_cnt, bus.fail_cnt, bus.timeout_cnt}, 0);
    check_eq("rst_err_fin", {bus.err_pulse, bus.finished}, 0);

    base = 0;
    rst = 1'b0;
    #1 check_eq("idle_eng_rst", bus.eng_rst, 0);
    @(negedge clk);
    check_eq("launch1_eng_rst", bus.eng_rst, 1);
    @(negedge clk);
    check_eq("wait1_eng_rst", bus.eng_rst, 0);

    lfsr_m = 32'hACE1;
    ep = 0; ef = 0; et = 0;
    for (int i = 0; i < int'(NT); i++) begin
      if (i == 0) begin ea = 14; eb = 161; end
      else begin ea = draw(); eb = draw(); end
      wait_launch(i + 1, $sformatf("A%0d", i));
      check_eq($sformatf("A%0d_a", i), bus.a_out, ea);
      check_eq($sformatf("A%0d_b", i), bus.b_out, eb);
      if (cfg[i].nodone) begin
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
          if (bus.timeout_cnt != 0) begin ok = 1'b1; break; end
          @(negedge clk);
        end
        delta = cyc - launch_cyc;
        check($sformatf("A%0d_timeout_lat", i), ok && delta >= TO + 1 && delta <= TO + 3,
              delta, TO + 2);
      end
      wait_tests(i + 1, $sformatf("A%0d", i));
      if (cfg[i].exp_ok) ep++; else ef++;
      if (cfg[i].exp_to) et++;
      check_eq($sformatf("A%0d_pass", i), bus.pass_cnt, ep);
      check_eq($sformatf("A%0d_fail", i), bus.fail_cnt, ef);
      check_eq($sformatf("A%0d_tout", i), bus.timeout_cnt, et);
      check_eq($sformatf("A%0d_errs", i), err_total, ef);
    end
    check_eq("A_err_width", err_maxw, 1);
    @(negedge clk);
    check_eq("A_finished", bus.finished, 1);
    check_eq("A_test_cnt", bus.test_cnt, NT);

    // Terminal state: everything frozen, engine held in reset.
    sa = bus.a_out; sb = bus.b_out;
    sc[0] = bus.test_cnt; sc[1] = bus.pass_cnt; sc[2] = bus.fail_cnt; sc[3] = bus.timeout_cnt;
    dev = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.eng_rst !== 1'b1 || bus.finished !== 1'b1 || bus.a_out !== sa || bus.b_out !== sb ||
          bus.test_cnt !== sc[0] || bus.pass_cnt !== sc[1] || bus.fail_cnt !== sc[2] ||
          bus.timeout_cnt !== sc[3] || bus.err_pulse !== 1'b0) dev++;
    end
    check_eq("A_frozen", dev, 0);

    // Run B: wrong result on test 1, correct test 2, reset during WAIT of test 3.
    rst = 1'b1;
    base = 8;
    err_maxw = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_tests(1, "B0");
    check_eq("B0_fail", bus.fail_cnt, 1);
    check_eq("B0_pass", bus.pass_cnt, 0);
    check_eq("B0_errs", err_total, 1);
    check_eq("B0_err_width", err_maxw, 1);
    wait_tests(2, "B1");
    check_eq("B1_pass", bus.pass_cnt, 1);
    wait_launch(3, "B2");
    repeat (5) @(negedge clk);
    check_eq("B2_pending", bus.test_cnt, 2);
    base = 12;
    rst = 1'b1;
    #1;
    check_eq("B2_rst_cnts", {bus.test_cnt, bus.pass_cnt, bus.fail_cnt, bus.timeout_cnt}, 0);
    check_eq("B2_rst_ops", {bus.a_out, bus.b_out}, 0);
    check_eq("B2_rst_eng_rst", bus.eng_rst, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Run C: restart from the fixed first pair.
    wait_launch(1, "C0");
    check_eq("C0_a", bus.a_out, 14);
    check_eq("C0_b", bus.b_out, 161);
    wait_tests(1, "C0");
    check_eq("C0_pass", bus.pass_cnt, 1);
    check_eq("C0_fail", bus.fail_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

endmodule
